// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: three-requester memory bus arbiter, fixed VGA priority, round-robin masters, bursts, stall timeout
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   req          - request per requester (0 = VGA, 1..2 = general masters)
//   req_ctrl     - packed control words, [2:0] burst length - 1, [3] write
//   mem_wait     - memory stall, current beat not accepted while high
//   ack          - one-hot grant to the owner
//   grant_sel    - index of the owner, valid while ack is non-zero
//   mem_ctrl     - owner's control word, 0 when nobody owns the bus
//   bus_busy     - high in address, data and turnaround phases
//   timeout_err  - sticky flag set by a stall-timeout abort
module mem_bus_arbiter #(
    parameter int CTRL_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              req,
    input  logic [3*CTRL_WIDTH-1:0] req_ctrl,
    input  logic                    mem_wait,
    output logic [2:0]              ack,
    output logic [1:0]              grant_sel,
    output logic [CTRL_WIDTH-1:0]   mem_ctrl,
    output logic                    bus_busy,
    output logic                    timeout_err
);
    typedef enum logic [1:0] {IDLE, GRANT, XFER, RELEASE} state_t;
    localparam logic [7:0] STALL_MAX = 8'(TIMEOUT);

    state_t                state, state_nx;
    logic                  rr, rr_nx;
    logic [2:0]            beat, beat_nx;
    logic [7:0]            stall, stall_nx;
    logic [1:0]            win;
    logic [CTRL_WIDTH-1:0] win_ctrl;
    logic                  go, beat_done, last_beat, stall_out, hold;
    logic [2:0]            ack_nx;
    logic [1:0]            grant_sel_nx;
    logic [CTRL_WIDTH-1:0] mem_ctrl_nx;
    logic                  bus_busy_nx, timeout_err_nx;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // rr high means requester 2 wins a 1-vs-2 tie
    always_comb begin
        win       = req[0] ? 2'd0 : (req[1] && !(req[2] && rr)) ? 2'd1 : 2'd2;
        go        = state == IDLE && |req;
        beat_done = state == XFER && !mem_wait;
        last_beat = beat_done && beat == 3'd0;
        stall_out = state == XFER && mem_wait && stall + 8'd1 == STALL_MAX;
        case (state)
            IDLE:    state_nx = go ? GRANT : IDLE;
            GRANT:   state_nx = XFER;
            XFER:    state_nx = (last_beat || stall_out) ? RELEASE : XFER;
            default: state_nx = IDLE;
        endcase
    end

    // next values of the registered outputs and counters
    always_comb begin
        win_ctrl       = req_ctrl[32'(win) * CTRL_WIDTH +: CTRL_WIDTH];
        hold           = state_nx == GRANT || state_nx == XFER;
        ack_nx         = !hold ? 3'b000 : go ? 3'b001 << win : ack;
        grant_sel_nx   = go ? win : grant_sel;
        mem_ctrl_nx    = !hold ? '0 : go ? win_ctrl : mem_ctrl;
        bus_busy_nx    = state_nx != IDLE;
        timeout_err_nx = timeout_err || stall_out;
        beat_nx        = go ? win_ctrl[2:0] : (beat_done && beat != 3'd0) ? beat - 3'd1 : beat;
        stall_nx       = (go || beat_done) ? 8'd0 : (state == XFER && mem_wait) ? stall + 8'd1 : stall;
        rr_nx          = (go && win != 2'd0) ? win == 2'd1 : rr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack         <= '0;
            grant_sel   <= '0;
            mem_ctrl    <= '0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b0;
            beat        <= '0;
            stall       <= '0;
            rr          <= 1'b0;
        end else begin
            ack         <= ack_nx;
            grant_sel   <= grant_sel_nx;
            mem_ctrl    <= mem_ctrl_nx;
            bus_busy    <= bus_busy_nx;
            timeout_err <= timeout_err_nx;
            beat        <= beat_nx;
            stall       <= stall_nx;
            rr          <= rr_nx;
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter CTRL_WIDTH, default 8, width of each requester control word and of mem_ctrl.
REQ-002 Parameter TIMEOUT, default 255, consecutive mem_wait-high cycles in XFER that abort a transfer.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  3  bus request per requester; bit 0 = VGA (real-time), bits 1-2 = general masters.
REQ-006 req_ctrl  input  3*CTRL_WIDTH  packed control words, requester i at [i*CTRL_WIDTH +: CTRL_WIDTH]; bits[2:0] = burst length minus 1, bit[3] = write; 0 = single-word read.
REQ-007 mem_wait  input  1  memory stall, the memory's ctrl bit 0; high = current beat not accepted.
REQ-008 ack  output  3  one-hot grant to the owning requester.
REQ-009 grant_sel  output  2  index of the owner, for external bus_out/bus_in muxes; valid while any ack bit is high.
REQ-010 mem_ctrl  output  CTRL_WIDTH  control word of the owner, latched at grant; 0 when idle.
REQ-011 bus_busy  output  1  high in GRANT, XFER and RELEASE.
REQ-012 timeout_err  output  1  sticky flag, set by a transfer abort.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, XFER and RELEASE; all outputs are registered.
REQ-014 IDLE: if any req bit is high, the next state SHALL be GRANT, with the winner chosen on that same cycle's req.
REQ-015 Priority: req[0] SHALL always win; between req[1] and req[2] the winner is round-robin.
REQ-016 Round-robin pointer: after a grant to 1 the pointer SHALL favour 2; after a grant to 2 it favours 1; a grant to 0 leaves it unchanged; reset value favours 1.
REQ-017 On entering GRANT: the winner's ack bit SHALL go high; grant_sel SHALL show the winner; mem_ctrl SHALL latch the winner's req_ctrl; a 3-bit beat counter SHALL be loaded with bits[2:0].
REQ-018 GRANT SHALL last exactly one cycle (address phase) and then go to XFER.
REQ-019 XFER: each cycle with mem_wait low completes one beat; on the beat that completes with the counter at 0, the next state SHALL be RELEASE; on any other completed beat the counter decrements.
REQ-020 A transfer of L words with no stalls SHALL hold ack high for exactly 1+L cycles.
REQ-021 No preemption: req[0] rising during XFER SHALL NOT end the current transfer.
REQ-022 A requester dropping req during GRANT or XFER SHALL NOT change the transfer; it runs to completion.
REQ-023 Timeout: a 8-bit stall counter SHALL increment each XFER cycle with mem_wait high and clear on a completed beat.
REQ-024 When the stall counter reaches TIMEOUT: the next state SHALL be RELEASE; timeout_err SHALL set and hold until reset.
REQ-025 RELEASE: ack SHALL be all zero, mem_ctrl 0 and bus_busy high for one turnaround cycle, then the next state is IDLE.
REQ-026 A requester still asserting req in IDLE after RELEASE SHALL be re-arbitrated normally.
REQ-027 A requester SHALL NOT be granted twice without passing through IDLE.
REQ-028 ack SHALL never have more than one bit set.

Reset
REQ-029 With reset high at a clock edge, the following edge state SHALL be: state IDLE; ack=000; grant_sel=0; mem_ctrl=0; bus_busy=0; timeout_err=0; beat and stall counters 0; round-robin pointer favours 1.
REQ-030 This reset behaviour SHALL apply even mid-transfer, with no RELEASE cycle.
REQ-031 Reset SHALL take priority over every other transition.

Verification
REQ-032 req=001, req_ctrl0=0, mem_wait=0 -> ack=001 for exactly 2 cycles, grant_sel=0, mem_ctrl=0, then one RELEASE cycle with bus_busy=1 and ack=000.
REQ-033 req=110 held continuously, each with a single-word read -> grants alternate 1,2,1,2; each grant is separated by RELEASE then IDLE.
REQ-034 Requester 1 bursts 4 words (ctrl=0x03); req[0] rises during XFER; mem_wait is high on 2 beats -> ack=010 for 7 cycles, then ack=001 after RELEASE and IDLE.
REQ-035 TIMEOUT=4, mem_wait stuck high in XFER -> RELEASE after 4 stall cycles; timeout_err=1 and stays 1 through later successful transfers.
REQ-036 reset asserted during XFER of an 8-word burst -> ack=000, bus_busy=0, mem_ctrl=0 on the next edge; a new req[2] after reset is granted normally.
